// File: rtl/fft_bitrev_reorder.sv
// ============================================================================
// Module      : fft_bitrev_reorder
// Description : Ping-pong reorder buffer behind the 16-point radix-2 SDF FFT.
//               Samples arrive in bit-reversed bin order and are written to
//               address bitrev(arrival index). Banks are then read
//               sequentially, so bins leave in natural order on a
//               valid/ready stream with sof/eof markers. The input cannot
//               stall, so a frame that finds no free bank is dropped whole
//               and the sticky overflow flag is raised.
//               Build option: FFT_REORDER_FFTSHIFT_EN emits bins
//               N/2..N-1 then 0..N/2-1 (fftshift order).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bitrev_reorder #(
  parameter int N_LOG2 = 4,
  parameter int DW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DW-1:0]     data_re_i,
  input  logic signed [DW-1:0]     data_im_i,
  input  logic                     valid_i,
  input  logic                     ready_i,
  output logic signed [DW-1:0]     data_re_o,
  output logic signed [DW-1:0]     data_im_o,
  output logic                     valid_o,
  output logic                     sof_o,
  output logic                     eof_o,
  output logic [N_LOG2-1:0]        idx_o,
  output logic                     overflow_o
);

  localparam int                N      = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] C_LAST = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] C_ONE  = N_LOG2'(1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Bank control state
  bank_state_e         bank_q [2];
  logic                wb_q;
  logic                rb_q;
  logic                drop_q;
  logic                overflow_q;
  logic [N_LOG2-1:0]   wr_cnt_q;
  logic [N_LOG2-1:0]   rd_cnt_q;

  // Storage: bank number is the address MSB
  logic [2*DW-1:0]     mem_q [2*N];

  // Output (RAM read) register
  logic [2*DW-1:0]     dout_q;
  logic                valid_q;
  logic                sof_q;
  logic                eof_q;
  logic [N_LOG2-1:0]   idx_q;

  logic                w_frame_start;
  logic                w_claim;
  logic                w_drop;
  logic                w_wr_en;
  logic                w_wr_done;
  logic                w_adv;
  logic                w_rd_ok;
  logic                w_rd_en;
  logic                w_rd_last;
  logic [N_LOG2-1:0]   w_rd_addr;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

  // A frame is accepted only if its target bank is EMPTY at the first sample;
  // the decision sticks for the remaining samples of that frame.
  assign w_frame_start = valid_i && (wr_cnt_q == '0);
  assign w_claim       = w_frame_start && (bank_q[wb_q] == EMPTY);
  assign w_drop        = w_frame_start ? !w_claim : drop_q;
  assign w_wr_en       = valid_i && !w_drop;
  assign w_wr_done     = w_wr_en && (wr_cnt_q == C_LAST);

  // Read side advances whenever the output register is empty or consumed.
  assign w_adv     = !valid_q || ready_i;
  assign w_rd_ok   = (bank_q[rb_q] == FULL) || (bank_q[rb_q] == DRAINING);
  assign w_rd_en   = w_adv && w_rd_ok;
  assign w_rd_last = (rd_cnt_q == C_LAST);

`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam logic [N_LOG2-1:0] C_MSB = N_LOG2'(N / 2);
  // Inverting the MSB starts the sweep at bin N/2 and wraps through bin N/2-1.
  assign w_rd_addr = rd_cnt_q ^ C_MSB;
`else
  assign w_rd_addr = rd_cnt_q;
`endif

  // Sample RAM write port; accepted samples land at their bin address.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[{wb_q, bitrev(wr_cnt_q)}] <= {data_re_i, data_im_i};
    end
  end

  // Bank bookkeeping: write counter/claims, read counter/release, overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      if (valid_i) begin
        wr_cnt_q <= wr_cnt_q + C_ONE;
      end
      if (w_frame_start) begin
        drop_q <= !w_claim;
        if (!w_claim) begin
          overflow_q <= 1'b1;
        end
      end
      if (w_claim) begin
        bank_q[wb_q] <= FILLING;
      end
      if (w_wr_done) begin
        bank_q[wb_q] <= FULL;
        wb_q         <= ~wb_q;
      end
      // The write bank is never FULL/DRAINING, so these never collide.
      if (w_rd_en) begin
        rd_cnt_q <= rd_cnt_q + C_ONE;
        if (w_rd_last) begin
          bank_q[rb_q] <= EMPTY;
          rb_q         <= ~rb_q;
        end else begin
          bank_q[rb_q] <= DRAINING;
        end
      end
    end
  end

  // Output register doubles as the synchronous RAM read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      idx_q   <= '0;
    end else if (w_adv) begin
      valid_q <= w_rd_ok;
      if (w_rd_ok) begin
        dout_q <= mem_q[{rb_q, w_rd_addr}];
        idx_q  <= w_rd_addr;
        sof_q  <= (rd_cnt_q == '0);
        eof_q  <= w_rd_last;
      end else begin
        sof_q <= 1'b0;
        eof_q <= 1'b0;
      end
    end
  end

  assign data_re_o  = dout_q[2*DW-1:DW];
  assign data_im_o  = dout_q[DW-1:0];
  assign valid_o    = valid_q;
  assign sof_o      = sof_q;
  assign eof_o      = eof_q;
  assign idx_o      = idx_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
// ============================================================================
// Module      : tb_fft_bitrev_reorder
// Description : Self-checking bench for fft_bitrev_reorder. A queue-based
//               model turns each accepted input frame into the expected
//               output sequence; a monitor compares every handshake and
//               checks that stalled outputs hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_bitrev_reorder;

  localparam int N_LOG2 = 4;
  localparam int N      = 16;
  localparam int DW     = 16;

`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SHIFT = N / 2;
`else
  localparam int SHIFT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     data_re_i;
  logic [DW-1:0]     data_im_i;
  logic              valid_i;
  logic              ready_i;
  logic [DW-1:0]     data_re_o;
  logic [DW-1:0]     data_im_o;
  logic              valid_o;
  logic              sof_o;
  logic              eof_o;
  logic [N_LOG2-1:0] idx_o;
  logic              overflow_o;

  fft_bitrev_reorder #(.N_LOG2(N_LOG2), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_re_i  (data_re_i),
    .data_im_i  (data_im_i),
    .valid_i    (valid_i),
    .ready_i    (ready_i),
    .data_re_o  (data_re_o),
    .data_im_o  (data_im_o),
    .valid_o    (valid_o),
    .sof_o      (sof_o),
    .eof_o      (eof_o),
    .idx_o      (idx_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
    bit            sof;
    bit            eof;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   run      = 0;
  int   max_run  = 0;
  int   n_hold   = 0;
  bit   exp_ovf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Arrival index whose bit-reversal equals bin b, built arithmetically.
  function automatic int rev4(input int b);
    int r = 0;
    for (int i = 0; i < N_LOG2; i++) r = r * 2 + ((b >> i) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nsamp samples; a complete kept frame is appended to the model.
  task automatic send_frame(input bit directed, input bit keep, input int nsamp);
    logic [DW-1:0] re [N];
    logic [DW-1:0] im [N];
    for (int k = 0; k < N; k++) begin
      re[k] = directed ? DW'(k) : DW'($urandom);
      im[k] = directed ? DW'(-k) : DW'($urandom);
    end
    if (keep && nsamp == N) begin
      for (int p = 0; p < N; p++) begin
        exp_t e;
        e.idx = (p + SHIFT) % N;
        e.re  = re[rev4(e.idx)];
        e.im  = im[rev4(e.idx)];
        e.sof = (p == 0);
        e.eof = (p == N - 1);
        q.push_back(e);
      end
    end
    for (int k = 0; k < nsamp; k++) begin
      valid_i   = 1'b1;
      data_re_i = re[k];
      data_im_i = im[k];
      if (k == 0) check("ovf_before_start", 64'(overflow_o), 64'(exp_ovf));
      tick();
      if (k == 0) begin
        if (!keep) exp_ovf = 1'b1;
        check("ovf_after_start", 64'(overflow_o), 64'(exp_ovf));
      end
    end
    valid_i = 1'b0;
  endtask

  // Run until the model queue and the output register are both empty.
  task automatic drain(input bit toggle, input int budget);
    int c = 0;
    while ((q.size() != 0 || valid_o) && c < budget) begin
      ready_i = toggle ? !ready_i : 1'b1;
      tick();
      c++;
    end
    check("drain_in_budget", 64'(c < budget), 64'd1);
    ready_i = 1'b1;
  endtask

  // Monitor: compare each handshake with the model and verify stall holds.
  initial begin
    bit          hold_pend = 1'b0;
    logic [63:0] h_vec = '0;
    logic [63:0] vec;
    exp_t        e;
    forever begin
      @(negedge clk);
      vec = {25'd0, valid_o, sof_o, eof_o, idx_o, data_re_o, data_im_o};
      if (rst) begin
        hold_pend = 1'b0;
        run       = 0;
      end else begin
        if (hold_pend) begin
          check("stall_hold", vec, h_vec);
          n_hold++;
        end
        run = valid_o ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (valid_o && ready_i) begin
          check("out_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("re", 64'(data_re_o), 64'(e.re));
            check("im", 64'(data_im_o), 64'(e.im));
            check("idx", 64'(idx_o), 64'(e.idx));
            check("sof", 64'(sof_o), 64'(e.sof));
            check("eof", 64'(eof_o), 64'(e.eof));
          end
        end
        hold_pend = valid_o && !ready_i;
        h_vec     = vec;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold0;
    int first;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_re_i = '0; data_im_i = '0;
    tick(); tick();
    check("reset_outputs", {valid_o, sof_o, eof_o, idx_o, data_re_o, data_im_o, overflow_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Single directed frame; bin 0 is valid right after the second edge,
    // counting the edge that sampled the last input.
    first = SHIFT;
    send_frame(1'b1, 1'b1, N);
    check("latency_not_yet", 64'(valid_o), 64'd0);
    tick();
    check("latency_first", {valid_o, sof_o, 4'(idx_o)}, {1'b1, 1'b1, 4'(first)});
    check("latency_first_re", 64'(data_re_o), 64'(rev4(first)));
    drain(1'b0, 100);

    // Four back-to-back random frames: one unbroken 64-sample burst.
    max_run = 0;
    for (int f = 0; f < 4; f++) send_frame(1'b0, 1'b1, N);
    drain(1'b0, 200);
    check("stream_contiguous", 64'(max_run), 64'd64);
    check("stream_no_ovf", 64'(overflow_o), 64'd0);

    // Backpressure: two frames stored, third dropped, then a fourth.
    ready_i = 1'b0;
    send_frame(1'b0, 1'b1, N);
    send_frame(1'b0, 1'b1, N);
    send_frame(1'b0, 1'b0, N);
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    check("two_frames_queued", 64'(q.size()), 64'd32);
    drain(1'b0, 200);
    send_frame(1'b0, 1'b1, N);
    drain(1'b0, 100);

    // Stall: ready toggles every cycle while the frame drains.
    hold0 = n_hold;
    send_frame(1'b0, 1'b1, N);
    drain(1'b1, 200);
    check("stall_seen", 64'(n_hold > hold0), 64'd1);

    // Reset after 7 inputs of a frame.
    send_frame(1'b0, 1'b0, 7);
    exp_ovf = overflow_o;
    rst = 1'b1;
    tick();
    check("rst_midframe", {valid_o, sof_o, eof_o, idx_o, data_re_o, data_im_o, overflow_o}, 64'd0);
    rst = 1'b0;
    exp_ovf = 1'b0;

    // Reset while a frame is draining.
    send_frame(1'b0, 1'b1, N);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_draining", {valid_o, sof_o, eof_o, idx_o, data_re_o, data_im_o, overflow_o}, 64'd0);
    q.delete();
    rst = 1'b0;

    // Fresh frame after reset reorders correctly.
    send_frame(1'b1, 1'b1, N);
    drain(1'b0, 100);
    send_frame(1'b0, 1'b1, N);
    drain(1'b0, 100);
    check("final_no_ovf", 64'(overflow_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
